// File: rtl/div_pkg.sv
// Shared constants and types for the divider family and its reconstruct partner.
//   DEF_WIDTH : default operand width
//   state_e   : control states of the sequential reconstructor
//   out_w()   : width of a reconstructed dividend for a given operand width
package div_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned out_w(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/div_reconstruct_seq_if.sv
// Request/result bundle for div_reconstruct_seq.
//   start, quotient, divisor, remainder : request side (master drives)
//   busy, done, dividend, inconsistent  : result side (slave drives)
interface div_reconstruct_seq_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  localparam int unsigned OUT_W = out_w(WIDTH);

  logic             start;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] dividend;
  logic             inconsistent;

  modport master (
    output start, quotient, divisor, remainder,
    input  busy, done, dividend, inconsistent
  );

  modport slave (
    input  start, quotient, divisor, remainder,
    output busy, done, dividend, inconsistent
  );

endinterface

// File: rtl/div_reconstruct_seq.sv
// Sequential inverse of the combinational divider: rebuilds
// dividend = quotient*divisor + remainder with a shift-add multiplier,
// one quotient bit per clock, and flags triples no legal division yields.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of div_reconstruct_seq_if (start/operands in,
//          busy/done/dividend/inconsistent out)
module div_reconstruct_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  div_reconstruct_seq_if.slave  bus
);

  localparam int unsigned OUT_W = out_w(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state_q;
  state_e             state_nxt;
  logic               busy_d;
  logic               done_d;
  logic               busy_q;
  logic               done_q;

  logic [OUT_W-1:0]   acc;
  logic [OUT_W-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               err_q;
  logic [OUT_W-1:0]   dividend_q;
  logic               inconsistent_q;

  logic               last;
  logic [OUT_W-1:0]   acc_sum;

  // Final multiplier step; the sum is bounded below 2^OUT_W so no carry is lost.
  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  // State register, with the registered handshake outputs tracking it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flops line up with it.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_nxt)
      RUN:     busy_d = 1'b1;
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Shift-add datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      cnt            <= '0;
      err_q          <= 1'b0;
      dividend_q     <= '0;
      inconsistent_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc    <= OUT_W'(bus.remainder);
            mcand  <= OUT_W'(bus.divisor);
            mplier <= bus.quotient;
            cnt    <= '0;
            err_q  <= (bus.divisor == '0) | (bus.remainder >= bus.divisor);
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            dividend_q     <= acc_sum;
            inconsistent_q <= err_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.dividend     = dividend_q;
  assign bus.inconsistent = inconsistent_q;

endmodule

// File: tb/tb_div_reconstruct_seq.sv
// Self-checking bench for div_reconstruct_seq (WIDTH=4) against an
// arithmetic reference model q*d+r with the legality rule d!=0 && r<d.
module tb_div_reconstruct_seq;

  localparam int unsigned W   = 4;
  localparam int unsigned OW  = 2 * W;
  localparam int          LAT = W + 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_reconstruct_seq_if #(.WIDTH(W)) bus ();

  div_reconstruct_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OW-1:0] ref_dividend(input int q, input int d, input int r);
    return OW'(q * d + r);
  endfunction

  function automatic logic ref_inconsistent(input int d, input int r);
    return (d == 0) || (r >= d);
  endfunction

  // One operation: start in the next cycle, then watch until done (bounded).
  task automatic do_op(input int q, input int d, input int r,
                       output logic [OW-1:0] res, output logic inc,
                       output int lat, output int busy_cycles);
    @(negedge clk);
    bus.quotient  = W'(q);
    bus.divisor   = W'(d);
    bus.remainder = W'(r);
    bus.start     = 1'b1;
    lat = 0;
    busy_cycles = 0;
    res = '0;
    inc = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start     = 1'b0;
        bus.quotient  = W'($urandom);
        bus.divisor   = W'($urandom);
        bus.remainder = W'($urandom);
      end
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        lat = i;
        res = bus.dividend;
        inc = bus.inconsistent;
        break;
      end
    end
  endtask

  task automatic check_op(input string name, input int q, input int d, input int r,
                          input bit check_timing);
    logic [OW-1:0] res;
    logic          inc;
    int            lat;
    int            bc;
    logic [OW-1:0] exp_res;
    logic          exp_inc;
    exp_res = ref_dividend(q, d, r);
    exp_inc = ref_inconsistent(d, r);
    do_op(q, d, r, res, inc, lat, bc);
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL %s timeout: no done within 20 cycles (q=%0d d=%0d r=%0d)", name, q, d, r);
    end
    checks++;
    if (res !== exp_res) begin
      errors++;
      $display("FAIL %s dividend: got %0d expected %0d (q=%0d d=%0d r=%0d)", name, res, exp_res, q, d, r);
    end
    checks++;
    if (inc !== exp_inc) begin
      errors++;
      $display("FAIL %s inconsistent: got %0b expected %0b (q=%0d d=%0d r=%0d)", name, inc, exp_inc, q, d, r);
    end
    if (check_timing) begin
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
      end
      checks++;
      if (bc !== LAT) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, LAT);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.quotient = '0;
    bus.divisor = '0;
    bus.remainder = '0;
    #12;
    checks++;
    if ({bus.busy, bus.done, bus.dividend, bus.inconsistent} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b dividend=%0d inc=%b expected all 0",
               bus.busy, bus.done, bus.dividend, bus.inconsistent);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    check_op("basic_3_5_2", 3, 5, 2, 1'b1);
    check_op("max_15_15_14", 15, 15, 14, 1'b1);
    check_op("zero_q", 0, 9, 4, 1'b1);
  endtask

  task automatic test_inconsistent();
    check_op("div_zero", 7, 0, 9, 1'b1);
    check_op("rem_eq_div", 1, 3, 3, 1'b1);
  endtask

  task automatic test_start_ignored();
    int dones;
    logic [OW-1:0] res;
    logic inc;
    dones = 0;
    res = '0;
    inc = 1'b0;
    @(negedge clk);
    bus.quotient  = W'(2);
    bus.divisor   = W'(6);
    bus.remainder = W'(1);
    bus.start     = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      bus.start = (i == 2 || i == 4);
      if (i == 2 || i == 4) begin
        bus.quotient  = W'(15);
        bus.divisor   = W'(15);
        bus.remainder = W'(14);
      end
      if (bus.done) begin
        dones++;
        res = bus.dividend;
        inc = bus.inconsistent;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_start done_count: got %0d expected 1", dones);
    end
    checks++;
    if (res !== OW'(13) || inc !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start result: got %0d/%0b expected 13/0", res, inc);
    end
  endtask

  task automatic test_back_to_back();
    check_op("b2b_a", 9, 11, 10, 1'b1);
    check_op("b2b_b", 4, 7, 0, 1'b1);
    check_op("b2b_c", 13, 2, 5, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    int dones;
    @(negedge clk);
    bus.quotient  = W'(5);
    bus.divisor   = W'(5);
    bus.remainder = W'(3);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    // A prior op left a nonzero dividend, so clearing is observable.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.dividend, bus.inconsistent} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b dividend=%0d inc=%b expected all 0",
               bus.busy, bus.done, bus.dividend, bus.inconsistent);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d busy/done cycles expected 0", dones);
    end
    check_op("after_reset", 6, 7, 2, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      check_op("random", int'($urandom_range(15)), int'($urandom_range(15)),
               int'($urandom_range(15)), 1'b0);
    end
  endtask

  // Round trip of every divider output, plus the illegal triples around them.
  task automatic test_sweep();
    for (int q = 0; q < 16; q++)
      for (int d = 0; d < 16; d++)
        for (int r = 0; r < 16; r++)
          check_op("sweep", q, d, r, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_inconsistent();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
